// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver.
//
// Frame: 1 start bit (0), DATA_WIDTH data bits LSB first, optional parity
// bit, 1 stop bit (1). RX_IN is synchronized through two flops; the
// synchronized line rx_s is the only internal view of the serial input.
//
// Each bit lasts PRESCALE clocks, counted by edge_cnt_r (0..PRESCALE-1).
// The sampled value is resolved at the end of the sample cycle, so its
// effect (shift, error flag, strobe) is visible one cycle later:
//   - default build: single sample at PRESCALE/2, visible at PRESCALE/2+1.
//   - UART_RX_MAJORITY_EN defined: samples at PRESCALE/2-1, PRESCALE/2 and
//     PRESCALE/2+1, 2-of-3 majority, visible at PRESCALE/2+2.
//
// PRESCALE, PAR_EN and PAR_TYP are captured when a start edge is seen and
// held for the whole frame. DATA_WIDTH must be at least 2.
//
// Outputs are registered. DATA_VALID, PAR_ERR and STP_ERR are one-cycle,
// mutually exclusive strobes; STP_ERR wins over PAR_ERR. P_DATA only
// updates together with DATA_VALID.

module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [PRESCALE_WIDTH-1:0] EDGE_ZERO = {PRESCALE_WIDTH{1'b0}};
  localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE  = PRESCALE_WIDTH'(1);
  localparam logic [BIT_CNT_W-1:0]      BIT_ZERO  = {BIT_CNT_W{1'b0}};
  localparam logic [BIT_CNT_W-1:0]      BIT_ONE   = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]      BIT_LAST  = BIT_CNT_W'(DATA_WIDTH - 1);

  // Expected parity bit: even parity makes the total number of ones even,
  // odd parity flips it.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic                  odd);
    parity_bit = (^data) ^ odd;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

  // ---------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------
  logic sync1_r;
  logic sync2_r;
  logic rx_s;

  // Two-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= RX_IN;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s = sync2_r;

  // ---------------------------------------------------------------------
  // State and frame configuration
  // ---------------------------------------------------------------------
  logic [2:0]                state_r,    state_n;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_r, edge_cnt_n;
  logic [BIT_CNT_W-1:0]      bit_cnt_r,  bit_cnt_n;
  logic [DATA_WIDTH-1:0]     shift_r,    shift_n;
  logic [PRESCALE_WIDTH-1:0] prescale_r, prescale_n;
  logic                      par_en_r,   par_en_n;
  logic                      par_typ_r,  par_typ_n;
  logic                      par_bad_r,  par_bad_n;
  logic [DATA_WIDTH-1:0]     p_data_n;
  logic                      data_valid_n;
  logic                      par_err_n;
  logic                      stp_err_n;

  logic [PRESCALE_WIDTH-1:0] half_s;
  logic                      bit_end_s;
  logic                      decide_s;
  logic                      bit_val_s;

  assign half_s    = {1'b0, prescale_r[PRESCALE_WIDTH-1:1]};
  assign bit_end_s = (edge_cnt_r == (prescale_r - EDGE_ONE));

`ifdef UART_RX_MAJORITY_EN
  logic samp_early_r;
  logic samp_mid_r;

  // Hold the early and middle samples; the late sample is taken live from
  // rx_s in the cycle the vote is resolved.
  always_ff @(posedge CLK) begin
    if (RST) begin
      samp_early_r <= 1'b1;
      samp_mid_r   <= 1'b1;
    end else begin
      if (edge_cnt_r == (half_s - EDGE_ONE)) begin
        samp_early_r <= rx_s;
      end else begin
        samp_early_r <= samp_early_r;
      end
      if (edge_cnt_r == half_s) begin
        samp_mid_r <= rx_s;
      end else begin
        samp_mid_r <= samp_mid_r;
      end
    end
  end

  assign decide_s  = (edge_cnt_r == (half_s + EDGE_ONE));
  assign bit_val_s = majority3(samp_early_r, samp_mid_r, rx_s);
`else
  assign decide_s  = (edge_cnt_r == half_s);
  assign bit_val_s = rx_s;
`endif

  // Next-state, datapath and output-strobe logic for the receive FSM.
  always_comb begin
    state_n      = state_r;
    edge_cnt_n   = edge_cnt_r;
    bit_cnt_n    = bit_cnt_r;
    shift_n      = shift_r;
    prescale_n   = prescale_r;
    par_en_n     = par_en_r;
    par_typ_n    = par_typ_r;
    par_bad_n    = par_bad_r;
    p_data_n     = P_DATA;
    data_valid_n = 1'b0;
    par_err_n    = 1'b0;
    stp_err_n    = 1'b0;

    case (state_r)
      IDLE: begin
        edge_cnt_n = EDGE_ZERO;
        bit_cnt_n  = BIT_ZERO;
        if (!rx_s) begin
          // Start edge: freeze the frame configuration.
          state_n    = START;
          prescale_n = PRESCALE;
          par_en_n   = PAR_EN;
          par_typ_n  = PAR_TYP;
          par_bad_n  = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end

      START: begin
        if (decide_s && bit_val_s) begin
          // Line was high again at the sample point: treat as a glitch.
          state_n    = IDLE;
          edge_cnt_n = EDGE_ZERO;
        end else if (bit_end_s) begin
          state_n    = DATA;
          edge_cnt_n = EDGE_ZERO;
        end else begin
          edge_cnt_n = edge_cnt_r + EDGE_ONE;
        end
      end

      DATA: begin
        if (decide_s) begin
          shift_n = {bit_val_s, shift_r[DATA_WIDTH-1:1]};
        end else begin
          shift_n = shift_r;
        end
        if (bit_end_s) begin
          edge_cnt_n = EDGE_ZERO;
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_n = BIT_ZERO;
            state_n   = par_en_r ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt_r + BIT_ONE;
          end
        end else begin
          edge_cnt_n = edge_cnt_r + EDGE_ONE;
        end
      end

      PARITY: begin
        if (decide_s) begin
          par_bad_n = (bit_val_s != parity_bit(shift_r, par_typ_r));
        end else begin
          par_bad_n = par_bad_r;
        end
        if (bit_end_s) begin
          state_n    = STOP;
          edge_cnt_n = EDGE_ZERO;
        end else begin
          edge_cnt_n = edge_cnt_r + EDGE_ONE;
        end
      end

      STOP: begin
        if (decide_s) begin
          // Leave without waiting out the stop bit so a back-to-back start
          // edge is not missed.
          state_n    = IDLE;
          edge_cnt_n = EDGE_ZERO;
          if (!bit_val_s) begin
            stp_err_n = 1'b1;
          end else if (par_bad_r) begin
            par_err_n = 1'b1;
          end else begin
            data_valid_n = 1'b1;
            p_data_n     = shift_r;
          end
        end else begin
          edge_cnt_n = edge_cnt_r + EDGE_ONE;
        end
      end

      default: begin
        state_n    = IDLE;
        edge_cnt_n = EDGE_ZERO;
        bit_cnt_n  = BIT_ZERO;
      end
    endcase
  end

  // State, configuration and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      edge_cnt_r <= EDGE_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      shift_r    <= {DATA_WIDTH{1'b0}};
      prescale_r <= PRESCALE_WIDTH'(8);
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      par_bad_r  <= 1'b0;
      P_DATA     <= {DATA_WIDTH{1'b0}};
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      state_r    <= state_n;
      edge_cnt_r <= edge_cnt_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      prescale_r <= prescale_n;
      par_en_r   <= par_en_n;
      par_typ_r  <= par_typ_n;
      par_bad_r  <= par_bad_n;
      P_DATA     <= p_data_n;
      DATA_VALID <= data_valid_n;
      PAR_ERR    <= par_err_n;
      STP_ERR    <= stp_err_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed self-checking bench for uart_rx.
// Frames are driven cycle by cycle on RX_IN at the falling clock edge;
// a monitor on the falling edge counts strobes and records received bytes.

module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc        = 0;
  int dv_cnt     = 0;
  int pe_cnt     = 0;
  int se_cnt     = 0;
  int multi_cnt  = 0;
  int strobe_cyc = 0;
  int frame_start = 0;
  logic [7:0] rx_q[$];

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_EXTRA = 1;
  localparam logic [7:0] GLITCH_EXP = 8'h81;
`else
  localparam int MAJ_EXTRA = 0;
  localparam logic [7:0] GLITCH_EXP = 8'h80;
`endif

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  // Cycle counter, advanced on the active edge.
  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      dv_cnt <= dv_cnt + 1;
      rx_q.push_back(P_DATA);
    end
    if (PAR_ERR === 1'b1) pe_cnt <= pe_cnt + 1;
    if (STP_ERR === 1'b1) se_cnt <= se_cnt + 1;
    if ((DATA_VALID === 1'b1) || (PAR_ERR === 1'b1) || (STP_ERR === 1'b1)) strobe_cyc <= cyc;
    if ((int'(DATA_VALID === 1'b1) + int'(PAR_ERR === 1'b1) + int'(STP_ERR === 1'b1)) > 1)
      multi_cnt <= multi_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drive one frame starting at a falling edge. glitch_idx inverts the line
  // for one cycle, abort_idx stops driving early, cfg_idx changes the
  // configuration pins mid-frame (-1 disables each).
  task automatic send_frame(input logic [7:0] data, input int p,
                            input logic par_present, input logic par_bit,
                            input logic stop_bit, input int glitch_idx,
                            input int abort_idx, input int cfg_idx);
    logic bits [0:10];
    int   nbits;
    int   limit;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (par_present) begin
      bits[9] = par_bit; bits[10] = stop_bit; nbits = 11;
    end else begin
      bits[9] = stop_bit; bits[10] = 1'b1; nbits = 10;
    end
    limit = (abort_idx >= 0) ? abort_idx : nbits * p;
    frame_start = cyc;
    for (int idx = 0; idx < limit; idx++) begin
      RX_IN = bits[idx / p] ^ (idx == glitch_idx);
      if (idx == cfg_idx) begin
        PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1;
      end
      @(negedge CLK);
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    idle(4);
    n_checks++; if (P_DATA !== 8'h00) $display("FAIL reset_p_data: got %h want 00", P_DATA); else n_pass++;
    n_checks++; if (DATA_VALID !== 1'b0) $display("FAIL reset_dv: got %b want 0", DATA_VALID); else n_pass++;
    n_checks++; if (PAR_ERR !== 1'b0) $display("FAIL reset_par_err: got %b want 0", PAR_ERR); else n_pass++;
    n_checks++; if (STP_ERR !== 1'b0) $display("FAIL reset_stp_err: got %b want 0", STP_ERR); else n_pass++;
    RST = 1'b0;
    idle(3);
  endtask

  task automatic test_basic();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt, s;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    s = frame_start;
    idle(20);
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL basic_dv_count: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== 8'h81) $display("FAIL basic_p_data: got %h want 81", P_DATA); else n_pass++;
    n_checks++; if (pe_cnt - pe0 !== 0) $display("FAIL basic_pe_count: got %0d want 0", pe_cnt - pe0); else n_pass++;
    n_checks++; if (se_cnt - se0 !== 0) $display("FAIL basic_se_count: got %0d want 0", se_cnt - se0); else n_pass++;
    n_checks++; if (strobe_cyc !== s + 80 + MAJ_EXTRA)
      $display("FAIL basic_latency: got %0d want %0d", strobe_cyc - s, 80 + MAJ_EXTRA); else n_pass++;
  endtask

  task automatic test_parity();
    int dv0 = dv_cnt, pe0 = pe_cnt, s;
    PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'h81, 16, 1'b1, 1'b0, 1'b1, -1, -1, -1);
    s = frame_start;
    idle(40);
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL par_ok_dv_count: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== 8'h81) $display("FAIL par_ok_p_data: got %h want 81", P_DATA); else n_pass++;
    n_checks++; if (pe_cnt - pe0 !== 0) $display("FAIL par_ok_pe_count: got %0d want 0", pe_cnt - pe0); else n_pass++;
    n_checks++; if (strobe_cyc !== s + 172 + MAJ_EXTRA)
      $display("FAIL par_latency: got %0d want %0d", strobe_cyc - s, 172 + MAJ_EXTRA); else n_pass++;
    dv0 = dv_cnt; pe0 = pe_cnt;
    send_frame(8'h81, 16, 1'b1, 1'b1, 1'b1, -1, -1, -1);
    idle(40);
    n_checks++; if (pe_cnt - pe0 !== 1) $display("FAIL par_bad_pe_count: got %0d want 1", pe_cnt - pe0); else n_pass++;
    n_checks++; if (dv_cnt - dv0 !== 0) $display("FAIL par_bad_dv_count: got %0d want 0", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== 8'h81) $display("FAIL par_bad_p_data_hold: got %h want 81", P_DATA); else n_pass++;
  endtask

  task automatic test_stop_err();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send_frame(8'hFF, 8, 1'b1, 1'b0, 1'b0, -1, -1, -1);
    idle(30);
    n_checks++; if (se_cnt - se0 !== 1) $display("FAIL stp_se_count: got %0d want 1", se_cnt - se0); else n_pass++;
    n_checks++; if (pe_cnt - pe0 !== 0) $display("FAIL stp_pe_count: got %0d want 0", pe_cnt - pe0); else n_pass++;
    n_checks++; if (dv_cnt - dv0 !== 0) $display("FAIL stp_dv_count: got %0d want 0", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== 8'h81) $display("FAIL stp_p_data_hold: got %h want 81", P_DATA); else n_pass++;
  endtask

  task automatic test_glitch();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    RX_IN = 1'b0; idle(2); RX_IN = 1'b1; idle(20);
    n_checks++; if (dv_cnt - dv0 !== 0) $display("FAIL glitch_dv_count: got %0d want 0", dv_cnt - dv0); else n_pass++;
    n_checks++; if (pe_cnt - pe0 !== 0) $display("FAIL glitch_pe_count: got %0d want 0", pe_cnt - pe0); else n_pass++;
    n_checks++; if (se_cnt - se0 !== 0) $display("FAIL glitch_se_count: got %0d want 0", se_cnt - se0); else n_pass++;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    idle(20);
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL glitch_next_dv_count: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== 8'h3C) $display("FAIL glitch_next_p_data: got %h want 3c", P_DATA); else n_pass++;
  endtask

  task automatic test_rst_midframe();
    int dv0 = dv_cnt;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, 44, -1);
    RST = 1'b1;
    idle(1);
    n_checks++; if (P_DATA !== 8'h00) $display("FAIL rst_mid_p_data: got %h want 00", P_DATA); else n_pass++;
    n_checks++; if (DATA_VALID !== 1'b0) $display("FAIL rst_mid_dv: got %b want 0", DATA_VALID); else n_pass++;
    n_checks++; if (PAR_ERR !== 1'b0) $display("FAIL rst_mid_par_err: got %b want 0", PAR_ERR); else n_pass++;
    n_checks++; if (STP_ERR !== 1'b0) $display("FAIL rst_mid_stp_err: got %b want 0", STP_ERR); else n_pass++;
    RST = 1'b0;
    idle(5);
    n_checks++; if (dv_cnt - dv0 !== 0) $display("FAIL rst_mid_partial_dv: got %0d want 0", dv_cnt - dv0); else n_pass++;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    idle(20);
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL rst_next_dv_count: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== 8'h5A) $display("FAIL rst_next_p_data: got %h want 5a", P_DATA); else n_pass++;
  endtask

  task automatic test_sample_glitch();
    int dv0 = dv_cnt;
    PRESCALE = 6'd8; PAR_EN = 1'b0;
    // Line index 13 reaches rx_s at the mid-sample cycle of data bit 0.
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 13, -1, -1);
    idle(20);
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL sglitch_dv_count: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== GLITCH_EXP) $display("FAIL sglitch_p_data: got %h want %h", P_DATA, GLITCH_EXP); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dv0 = dv_cnt, s2;
    PRESCALE = 6'd32; PAR_EN = 1'b0;
    send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1, -1, -1, -1);
    s2 = frame_start;
    idle(60);
    n_checks++; if (dv_cnt - dv0 !== 2) $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - dv0); else n_pass++;
    if (rx_q.size() >= 2) begin
      n_checks++; if (rx_q[rx_q.size()-2] !== 8'h3C) $display("FAIL b2b_first: got %h want 3c", rx_q[rx_q.size()-2]); else n_pass++;
      n_checks++; if (rx_q[rx_q.size()-1] !== 8'hC3) $display("FAIL b2b_second: got %h want c3", rx_q[rx_q.size()-1]); else n_pass++;
    end else begin
      n_checks++; $display("FAIL b2b_queue: got %0d bytes want at least 2", rx_q.size());
    end
    n_checks++; if (strobe_cyc !== s2 + 308 + MAJ_EXTRA)
      $display("FAIL b2b_latency: got %0d want %0d", strobe_cyc - s2, 308 + MAJ_EXTRA); else n_pass++;
  endtask

  task automatic test_config_hold();
    int dv0 = dv_cnt, pe0 = pe_cnt, se0 = se_cnt;
    PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    // Pins switch to 8 / parity / odd in the middle of a 16-clock frame.
    send_frame(8'h96, 16, 1'b0, 1'b0, 1'b1, -1, -1, 40);
    idle(40);
    n_checks++; if (dv_cnt - dv0 !== 1) $display("FAIL cfg_hold_dv_count: got %0d want 1", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== 8'h96) $display("FAIL cfg_hold_p_data: got %h want 96", P_DATA); else n_pass++;
    // Next frame uses the new pins: 0x69 has four ones, odd parity bit 1.
    send_frame(8'h69, 8, 1'b1, 1'b1, 1'b1, -1, -1, -1);
    idle(30);
    n_checks++; if (dv_cnt - dv0 !== 2) $display("FAIL cfg_next_dv_count: got %0d want 2", dv_cnt - dv0); else n_pass++;
    n_checks++; if (P_DATA !== 8'h69) $display("FAIL cfg_next_p_data: got %h want 69", P_DATA); else n_pass++;
    n_checks++; if ((pe_cnt - pe0) + (se_cnt - se0) !== 0)
      $display("FAIL cfg_errors: got %0d want 0", (pe_cnt - pe0) + (se_cnt - se0)); else n_pass++;
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_rst_midframe();
    test_sample_glitch();
    test_back_to_back();
    test_config_hold();
    n_checks++; if (multi_cnt !== 0) $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", multi_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the receive-side counterpart of the team's `UART_TX` transmitter. It uses the same frame format: one start bit (0), 8 data bits LSB first, an optional parity bit, and one stop bit (1). It recovers the serial stream on `RX_IN` using a programmable oversampling prescale. It then presents the byte as a single-cycle `DATA_VALID` strobe with `P_DATA`, and flags parity and stop-bit errors. The block sits between the pad-side serial line and the system-side byte consumer.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `PRESCALE_WIDTH`, default 6: width of the `PRESCALE` input.
- `CLK` input, 1 bit: clock; all logic is on the rising edge.
- `RST` input, 1 bit: reset. Synchronous, active-high.
- `RX_IN` input, 1 bit: serial line; idles high; asynchronous to `CLK`.
- `PRESCALE` input, `PRESCALE_WIDTH` bits: clocks per bit. Legal values are 8, 16 and 32; the value is held static during a frame.
- `PAR_EN` input, 1 bit: 1 means a parity bit is present.
- `PAR_TYP` input, 1 bit: 0 for even parity, 1 for odd. Ignored when `PAR_EN`=0.
- `P_DATA` output, `DATA_WIDTH` bits: last correctly received byte.
- `DATA_VALID` output, 1 bit: one-cycle strobe; `P_DATA` is valid in that cycle.
- `PAR_ERR` output, 1 bit: one-cycle strobe on a parity mismatch.
- `STP_ERR` output, 1 bit: one-cycle strobe when the stop bit is sampled as 0.

## Operation
- `RX_IN` passes through a 2-flop synchronizer; the output `rx_s` is the only internal use of the line.
- `PAR_EN`, `PAR_TYP` and `PRESCALE` are captured on the IDLE to START transition and held for the whole frame.
- `edge_cnt` counts 0..`PRESCALE`-1 within each bit. `bit_cnt` counts data bits 0..`DATA_WIDTH`-1.
- Sample point: `edge_cnt` == `PRESCALE`/2. The bit decision is taken at `edge_cnt` == `PRESCALE`/2+1 (see Configuration).
- FSM states and transitions:
  - IDLE: on `rx_s`=0, go to START with `edge_cnt`=0.
  - START: at the decision point, go to IDLE if the start bit is 1 (glitch). Otherwise continue to the end of the bit, then go to DATA.
  - DATA: at each decision, shift the bit into the shift register LSB-first. After bit `DATA_WIDTH`-1 ends, go to PARITY if the captured `PAR_EN`=1, else go to STOP.
  - PARITY: at the decision, compare the bit against the XOR of the data, inverted for odd parity. Record the mismatch. At the end of the bit, go to STOP.
  - STOP: at the decision, act on the result and go directly to IDLE. The remaining half stop bit is not waited out, so a back-to-back start edge is caught.
    - Stop bit 0: pulse `STP_ERR`.
    - Otherwise, parity mismatch recorded: pulse `PAR_ERR`.
    - Otherwise: load `P_DATA` and pulse `DATA_VALID`.
- At most one of `DATA_VALID`, `PAR_ERR`, `STP_ERR` is high in any cycle. `STP_ERR` has priority over `PAR_ERR`.
- `P_DATA` changes only with `DATA_VALID`. It holds its value on any error frame.
- Changes to `PAR_EN`, `PAR_TYP` or `PRESCALE` mid-frame take effect on the next frame only.

## Timing
- Reset values:
  - `P_DATA`=0; `DATA_VALID`, `PAR_ERR`, `STP_ERR`=0.
  - FSM=IDLE; counters 0; synchronizer flops 1.
- `RST` asserted mid-frame: next cycle is IDLE with all outputs 0, and the partial frame is discarded. Reception resumes on the first falling `rx_s` after `RST` deasserts.
- Latency:
  - The start edge on `RX_IN` reaches IDLE detection 2 cycles later.
  - With no parity, the strobe rises `PRESCALE`×9 + `PRESCALE`/2 + 2 cycles after the first cycle `rx_s`=0. Add `PRESCALE` cycles when parity is enabled.
- Strobes are exactly 1 cycle wide. A new frame may start the cycle after the strobe.
- A low pulse shorter than `PRESCALE`/2 cycles on an idle line produces no output.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit is sampled at `edge_cnt` = `PRESCALE`/2-1, `PRESCALE`/2 and `PRESCALE`/2+1.
  - The bit value is the 2-of-3 majority.
  - The decision is taken at `PRESCALE`/2+2, adding 1 cycle to the latency above.
- `UART_RX_MAJORITY_EN` undefined:
  - A single sample is taken at `PRESCALE`/2 and decided at `PRESCALE`/2+1.
  - A single-cycle glitch at the sample point corrupts the bit.

## Test plan
- `PRESCALE`=8, `PAR_EN`=0, frame for 0x81 → one `DATA_VALID` pulse, `P_DATA`=0x81, no error strobes.
- `PRESCALE`=16, `PAR_EN`=1, `PAR_TYP`=0, 0x81 with parity bit 0 → `P_DATA`=0x81 valid. Repeat with parity bit 1 → `PAR_ERR` pulse, no `DATA_VALID`, `P_DATA` stays 0x81.
- `PRESCALE`=8, 0xFF with `PAR_TYP`=1 and parity bit 0, then stop bit forced 0 → single `STP_ERR` pulse only; `P_DATA` unchanged.
- Idle line with a 2-cycle low glitch at `PRESCALE`=8 → no strobes; FSM back in IDLE; a following valid 0x3C frame is received correctly.
- `RST` asserted during data bit 4 of a 0xA5 frame → all outputs 0 next cycle; a following 0x5A frame yields `P_DATA`=0x5A.
- With `UART_RX_MAJORITY_EN` defined: a 1-cycle inverted glitch exactly at the mid-sample of data bit 0 of 0x81 → still `P_DATA`=0x81. Without the macro → `P_DATA`=0x80.
